// File: rtl/dense_pos_stream_gen_pkg.sv
// dense_pos_stream_gen_pkg: sparse-stream token widths, control token encodings and generator state type.
package dense_pos_stream_gen_pkg;
  localparam int DATA_W = 16;
  localparam int TOKEN_W = DATA_W + 1;
  localparam int STOP_LVL_W = 8;
  localparam logic [TOKEN_W-1:0] STOP_BASE = 17'h10000;
  localparam logic [TOKEN_W-1:0] DONE_TOKEN = 17'h10100;
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP, S_DONE} state_t;
  function automatic logic [TOKEN_W-1:0] mk_stop(input logic [STOP_LVL_W-1:0] lvl);
    return STOP_BASE | {{(TOKEN_W-STOP_LVL_W){1'b0}}, lvl};
  endfunction
endpackage

// File: rtl/dense_pos_stream_gen_if.sv
// dense_pos_stream_gen_if: valid/ready token channel from the position generator to its consumer.
interface dense_pos_stream_gen_if;
  import dense_pos_stream_gen_pkg::*;
  logic [TOKEN_W-1:0] pos_out;
  logic pos_out_valid;
  logic pos_out_ready;
  modport master(output pos_out, output pos_out_valid, input pos_out_ready);
  modport slave(input pos_out, input pos_out_valid, output pos_out_ready);
endinterface

// File: rtl/dense_pos_stream_gen_token_out_reg.sv
// token_out_reg: single-entry registered output stage; load takes priority, a transfer empties it.
module token_out_reg
  import dense_pos_stream_gen_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clk_en,
  input  logic               clr,
  input  logic               load,
  input  logic [TOKEN_W-1:0] din,
  input  logic               ready,
  output logic [TOKEN_W-1:0] dout,
  output logic               valid
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
      valid <= 1'b0;
    end else if (clr) begin
      dout <= '0;
      valid <= 1'b0;
    end else if (clk_en) begin
      if (load) begin
        dout <= din;
        valid <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/dense_pos_stream_gen.sv
// dense_pos_stream_gen: emits num_fibers fibers of dim dense positions with S0/S1 stops and a final DONE token.
module dense_pos_stream_gen
  import dense_pos_stream_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              flush,
  input  logic              tile_en,
  input  logic              start,
  input  logic [DATA_W-1:0] dim,
  input  logic [DATA_W-1:0] num_fibers,
  dense_pos_stream_gen_if.master pos,
  output logic              busy,
  output logic              done
);
  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);
  state_t state, state_n;
  logic [DATA_W-1:0] dim_r, nf_r, pos_cnt, pos_cnt_n, fib_cnt, fib_cnt_n, base, base_n;
  logic [TOKEN_W-1:0] tok;
  logic load, xfer, clr, done_q, done_n, last_pos, last_fib;
  assign clr = flush | ~tile_en;
  assign xfer = pos.pos_out_valid & pos.pos_out_ready;
  assign last_pos = pos_cnt == dim_r - ONE;
  assign last_fib = fib_cnt == nf_r - ONE;
  assign done = done_q & clk_en;
  // State names the token currently held in the output register; the next one is loaded on its transfer.
  always_comb begin
    state_n = state;
    load = 1'b0;
    tok = '0;
    pos_cnt_n = pos_cnt;
    fib_cnt_n = fib_cnt;
    base_n = base;
    done_n = 1'b0;
    case (state)
      S_IDLE: if (start) begin
        load = 1'b1;
        pos_cnt_n = '0;
        fib_cnt_n = '0;
        base_n = '0;
        state_n = num_fibers == '0 ? S_DONE : dim == '0 ? S_STOP : S_DATA;
        tok = num_fibers == '0 ? DONE_TOKEN : dim == '0 ? mk_stop(STOP_LVL_W'(num_fibers == ONE)) : '0;
      end
      S_DATA: if (xfer) begin
        load = 1'b1;
        state_n = last_pos ? S_STOP : S_DATA;
        pos_cnt_n = last_pos ? pos_cnt : pos_cnt + ONE;
        tok = last_pos ? mk_stop(STOP_LVL_W'(last_fib)) : {1'b0, base + pos_cnt + ONE};
      end
      S_STOP: if (xfer) begin
        load = 1'b1;
        if (last_fib) begin
          state_n = S_DONE;
          tok = DONE_TOKEN;
        end else begin
          fib_cnt_n = fib_cnt + ONE;
          base_n = base + dim_r;
          pos_cnt_n = '0;
          state_n = dim_r == '0 ? S_STOP : S_DATA;
          tok = dim_r == '0 ? mk_stop(STOP_LVL_W'(fib_cnt + ONE == nf_r - ONE)) : {1'b0, base + dim_r};
        end
      end
      S_DONE: if (xfer) begin
        state_n = S_IDLE;
        done_n = 1'b1;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      {dim_r, nf_r, pos_cnt, fib_cnt, base} <= '0;
      busy <= 1'b0;
      done_q <= 1'b0;
    end else if (clr) begin
      state <= S_IDLE;
      {dim_r, nf_r, pos_cnt, fib_cnt, base} <= '0;
      busy <= 1'b0;
      done_q <= 1'b0;
    end else if (clk_en) begin
      state <= state_n;
      pos_cnt <= pos_cnt_n;
      fib_cnt <= fib_cnt_n;
      base <= base_n;
      busy <= state_n != S_IDLE;
      done_q <= done_n;
      if (state == S_IDLE) begin
        dim_r <= dim;
        nf_r <= num_fibers;
      end
    end
  end
  token_out_reg u_out (
    .clk(clk),
    .rst_n(rst_n),
    .clk_en(clk_en),
    .clr(clr),
    .load(load),
    .din(tok),
    .ready(pos.pos_out_ready),
    .dout(pos.pos_out),
    .valid(pos.pos_out_valid)
  );
endmodule

// File: tb/tb_dense_pos_stream_gen.sv
// tb_dense_pos_stream_gen: table-driven runs checked through a token scoreboard, plus flush/reset/clk_en sequences.
module tb_dense_pos_stream_gen;
  typedef struct {
    logic [15:0] dim;
    logic [15:0] nf;
    bit rnd;
    int exp_cnt;
  } vec_t;
  logic clk, rst_n, clk_en, flush, tile_en, start, busy, done;
  logic [15:0] dim, nf;
  dense_pos_stream_gen_if bus();
  int total = 0, bad = 0, xfers = 0, done_cnt = 0;
  logic [16:0] exp_q[$];
  bit rnd_mode = 0, ready_force = 1, hold_prev = 0;
  logic [16:0] prev_val = '0;
  vec_t tbl[6];

  dense_pos_stream_gen dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .flush(flush), .tile_en(tile_en),
    .start(start), .dim(dim), .num_fibers(nf), .pos(bus), .busy(busy), .done(done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    bus.pos_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      bus.pos_out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) hold_prev = 0;
    else begin
      if (hold_prev && bus.pos_out_valid) chk("stable", 32'(bus.pos_out), 32'(prev_val));
      if (bus.pos_out_valid) begin
        chk("busy_with_valid", 32'(busy), 1);
        if (clk_en && bus.pos_out_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_tok: got %0h expected none", bus.pos_out);
          end else chk("tok", 32'(bus.pos_out), 32'(exp_q.pop_front()));
          xfers++;
        end
      end
      hold_prev = bus.pos_out_valid && !(clk_en && bus.pos_out_ready);
      prev_val = bus.pos_out;
      if (done) done_cnt++;
    end
  end

  task automatic push_model(input int d, input int n);
    for (int f = 0; f < n; f++) begin
      for (int i = 0; i < d; i++) exp_q.push_back({1'b0, 16'(f * d + i)});
      exp_q.push_back(f == n - 1 ? 17'h10001 : 17'h10000);
    end
    exp_q.push_back(17'h10100);
  endtask

  task automatic kick(input logic [15:0] d, input logic [15:0] n);
    dim = d;
    nf = n;
    @(posedge clk);
    #1 start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask

  task automatic run(input logic [15:0] d, input logic [15:0] n, input bit rnd, input int exp_cnt, input bit disturb);
    int x0, d0, cyc;
    x0 = xfers;
    d0 = done_cnt;
    rnd_mode = rnd;
    kick(d, n);
    @(negedge clk);
    chk("first_valid", 32'(bus.pos_out_valid), 1);
    chk("busy_after_start", 32'(busy), 1);
    cyc = 0;
    while (done_cnt == d0 && cyc < 2000) begin
      @(posedge clk);
      #1 cyc++;
      if (disturb) begin
        if (cyc == 3) clk_en = 0;
        if (cyc == 4) begin start = 1; dim = 16'd7; end
        if (cyc == 5) start = 0;
        if (cyc == 8) clk_en = 1;
        if (cyc == 9) start = 1;
        if (cyc == 10) start = 0;
      end
    end
    rnd_mode = 0;
    if (cyc >= 2000) begin
      total++;
      bad++;
      $display("FAIL timeout: got no done within %0d cycles", cyc);
    end
    chk("len", 32'(xfers - x0), 32'(exp_cnt));
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    if (!rnd && !disturb) chk("cycles", 32'(cyc), 32'(exp_cnt + 1));
    @(negedge clk);
    chk("busy_end", 32'(busy), 0);
    chk("valid_end", 32'(bus.pos_out_valid), 0);
    chk("single_done", 32'(done_cnt - d0), 1);
  endtask

  task automatic wait_xfers(input int x0, input int n);
    int cyc;
    cyc = 0;
    while (xfers - x0 < n && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
    if (cyc >= 200) begin
      total++;
      bad++;
      $display("FAIL wait_xfers: got %0d transfers expected %0d", xfers - x0, n);
    end
  endtask

  initial begin
    int x0;
    tbl[0] = '{dim: 16'd3, nf: 16'd2, rnd: 1'b1, exp_cnt: 9};
    tbl[1] = '{dim: 16'd0, nf: 16'd3, rnd: 1'b0, exp_cnt: 4};
    tbl[2] = '{dim: 16'd5, nf: 16'd0, rnd: 1'b0, exp_cnt: 1};
    tbl[3] = '{dim: 16'd4, nf: 16'd3, rnd: 1'b1, exp_cnt: 16};
    tbl[4] = '{dim: 16'd1, nf: 16'd1, rnd: 1'b0, exp_cnt: 3};
    tbl[5] = '{dim: 16'd0, nf: 16'd1, rnd: 1'b1, exp_cnt: 2};
    rst_n = 0; clk_en = 1; flush = 0; tile_en = 1; start = 0; dim = 0; nf = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pos_out", 32'(bus.pos_out), 0);
    chk("rst_valid", 32'(bus.pos_out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    @(posedge clk);
    #1 rst_n = 1;
    tile_en = 0;
    kick(16'd3, 16'd2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("tile_off_valid", 32'(bus.pos_out_valid), 0);
    chk("tile_off_busy", 32'(busy), 0);
    tile_en = 1;
    exp_q = '{17'h00000, 17'h00001, 17'h00002, 17'h10000, 17'h00003, 17'h00004, 17'h00005, 17'h10001, 17'h10100};
    run(16'd3, 16'd2, 0, 9, 0);
    for (int k = 0; k < 6; k++) begin
      push_model(int'(tbl[k].dim), int'(tbl[k].nf));
      run(tbl[k].dim, tbl[k].nf, tbl[k].rnd, tbl[k].exp_cnt, 0);
    end
    push_model(3, 2);
    run(16'd3, 16'd2, 0, 9, 1);
    for (int v = 0; v < 2; v++) begin
      exp_q.delete();
      push_model(3, 2);
      x0 = xfers;
      kick(16'd3, 16'd2);
      wait_xfers(x0, 4);
      ready_force = 0;
      if (v == 0) begin
        flush = 1;
        @(posedge clk);
        #1 flush = 0;
      end else rst_n = 0;
      @(negedge clk);
      chk(v == 0 ? "flush_valid" : "rstn_valid", 32'(bus.pos_out_valid), 0);
      chk(v == 0 ? "flush_busy" : "rstn_busy", 32'(busy), 0);
      chk(v == 0 ? "flush_pos" : "rstn_pos", 32'(bus.pos_out), 0);
      @(posedge clk);
      #1 rst_n = 1;
      ready_force = 1;
      exp_q.delete();
      push_model(3, 2);
      run(16'd3, 16'd2, 0, 9, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
